// File: rtl/cache_axi_line_bridge.sv
// Cache line refill/writeback bridge onto AXI4 INCR bursts of LINE_WORDS 32-bit beats.
// Optional macro WR_EARLY_ACK_EN: acknowledge writebacks after the last W beat instead of after B.
module cache_axi_line_bridge #(
  parameter int LINE_WORDS = 4,
  localparam int LINE_W = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [31:0]       rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic [LINE_W-1:0] ret_data,
  input  logic              wr_req,
  input  logic [31:0]       wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_rdy,
  output logic              wr_valid,
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int OFF = CW + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rstate_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} wstate_t;

`ifdef WR_EARLY_ACK_EN
  localparam wstate_t W_AFTER_DATA = W_DONE;
`else
  localparam wstate_t W_AFTER_DATA = W_RESP;
`endif

  rstate_t           rstate_q, rstate_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic              rd_idle_q, rd_idle_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d, ret_valid_q, ret_valid_d;

  wstate_t           wstate_q, wstate_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_rdy_q, wr_rdy_d, awvalid_d, awvalid_q, wvalid_d, wvalid_q;
  logic              wlast_d, wlast_q, bready_d, bready_q, wr_valid_d, wr_valid_q;

  logic wr_blocking, raw_hit;

  // A read to the line being written back waits until the write is acknowledged.
`ifdef WR_EARLY_ACK_EN
  assign wr_blocking = (wstate_q == W_ADDR) || (wstate_q == W_DATA);
`else
  assign wr_blocking = (wstate_q != W_IDLE);
`endif
  assign raw_hit = wr_blocking && ((rd_addr & LINE_MASK) == awaddr_q);
  assign rd_rdy  = rd_idle_q && !raw_hit;

  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    araddr_d = araddr_q;
    rline_d  = rline_q;
    case (rstate_q)
      R_IDLE: if (rd_req && rd_rdy) begin
        rstate_d = R_ADDR;
        araddr_d = rd_addr & LINE_MASK;
        rcnt_d   = '0;
      end
      R_ADDR: if (arready) rstate_d = R_DATA;
      R_DATA: if (rvalid) begin
        rline_d[32*int'(rcnt_q) +: 32] = rdata;
        if (rcnt_q != LAST) rcnt_d = rcnt_q + 1'b1;
        if (rlast) rstate_d = R_DONE;
      end
      R_DONE: rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
    rd_idle_d   = (rstate_d == R_IDLE);
    arvalid_d   = (rstate_d == R_ADDR);
    rready_d    = (rstate_d == R_DATA);
    ret_valid_d = (rstate_d == R_DONE);
  end

  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    awaddr_d = awaddr_q;
    wline_d  = wline_q;
    case (wstate_q)
      W_IDLE: if (wr_req && wr_rdy_q) begin
        wstate_d = W_ADDR;
        awaddr_d = wr_addr & LINE_MASK;
        wline_d  = wr_data;
        wcnt_d   = '0;
      end
      W_ADDR: if (awready) wstate_d = W_DATA;
      W_DATA: if (wready) begin
        if (wlast_q) wstate_d = W_AFTER_DATA;
        else wcnt_d = wcnt_q + 1'b1;
      end
`ifdef WR_EARLY_ACK_EN
      W_DONE: wstate_d = W_RESP;
      W_RESP: if (bvalid) wstate_d = W_IDLE;
`else
      W_RESP: if (bvalid) wstate_d = W_DONE;
      W_DONE: wstate_d = W_IDLE;
`endif
      default: wstate_d = W_IDLE;
    endcase
    // W payload is registered from the beat index it will present next cycle.
    wr_rdy_d   = (wstate_d == W_IDLE);
    awvalid_d  = (wstate_d == W_ADDR);
    wvalid_d   = (wstate_d == W_DATA);
    wlast_d    = (wstate_d == W_DATA) && (wcnt_d == LAST);
    wdata_d    = (wstate_d == W_DATA) ? wline_q[32*int'(wcnt_d) +: 32] : 32'd0;
    bready_d   = (wstate_d == W_RESP);
    wr_valid_d = (wstate_d == W_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= R_IDLE;      rcnt_q <= '0;          araddr_q <= '0;
      rline_q <= '0;           rd_idle_q <= 1'b0;     arvalid_q <= 1'b0;
      rready_q <= 1'b0;        ret_valid_q <= 1'b0;
      wstate_q <= W_IDLE;      wcnt_q <= '0;          awaddr_q <= '0;
      wline_q <= '0;           wdata_q <= '0;         wr_rdy_q <= 1'b0;
      awvalid_q <= 1'b0;       wvalid_q <= 1'b0;      wlast_q <= 1'b0;
      bready_q <= 1'b0;        wr_valid_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;    rcnt_q <= rcnt_d;      araddr_q <= araddr_d;
      rline_q <= rline_d;      rd_idle_q <= rd_idle_d; arvalid_q <= arvalid_d;
      rready_q <= rready_d;    ret_valid_q <= ret_valid_d;
      wstate_q <= wstate_d;    wcnt_q <= wcnt_d;      awaddr_q <= awaddr_d;
      wline_q <= wline_d;      wdata_q <= wdata_d;    wr_rdy_q <= wr_rdy_d;
      awvalid_q <= awvalid_d;  wvalid_q <= wvalid_d;  wlast_q <= wlast_d;
      bready_q <= bready_d;    wr_valid_q <= wr_valid_d;
    end
  end

  assign ret_valid = ret_valid_q;
  assign ret_data  = rline_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign wr_rdy    = wr_rdy_q;
  assign wr_valid  = wr_valid_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wlast     = wlast_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
endmodule
